// File: rtl/wb_cdb_arbiter_if.sv
// wb_cdb_arbiter_if: MEM/ALU result inputs, flush, and CDB broadcast bundle; slave = arbiter side, master = producer/consumer side
interface wb_cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4
);
  logic              flush;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_rd_we;
  logic [PREG_W-1:0] mem_prd;
  logic [ROB_W-1:0]  mem_rob_idx;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic              alu_rd_we;
  logic [PREG_W-1:0] alu_prd;
  logic [ROB_W-1:0]  alu_rob_idx;
  logic [DATA_W-1:0] alu_data;
  logic              cdb_valid;
  logic              cdb_ready;
  logic              cdb_rd_we;
  logic [PREG_W-1:0] cdb_prd;
  logic [ROB_W-1:0]  cdb_rob_idx;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_src;
  modport slave (
    input  flush, mem_valid, mem_rd_we, mem_prd, mem_rob_idx, mem_data,
    input  alu_valid, alu_rd_we, alu_prd, alu_rob_idx, alu_data, cdb_ready,
    output mem_ready, alu_ready,
    output cdb_valid, cdb_rd_we, cdb_prd, cdb_rob_idx, cdb_data, cdb_src
  );
  modport master (
    output flush, mem_valid, mem_rd_we, mem_prd, mem_rob_idx, mem_data,
    output alu_valid, alu_rd_we, alu_prd, alu_rob_idx, alu_data, cdb_ready,
    input  mem_ready, alu_ready,
    input  cdb_valid, cdb_rd_we, cdb_prd, cdb_rob_idx, cdb_data, cdb_src
  );
endinterface

// File: rtl/wb_cdb_arbiter.sv
// wb_cdb_arbiter: per-source FIFOs for MEM (src 0) and ALU (src 1) results, round-robin onto a registered CDB; ports clk, rst, bus (slave)
module wb_cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int PREG_W     = 6,
  parameter int ROB_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  wb_cdb_arbiter_if.slave   bus
);
  localparam int E_W   = 1 + PREG_W + ROB_W + DATA_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [E_W-1:0]   r_fifo [2][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wp [2];
  logic [PTR_W-1:0] r_rp [2];
  logic [CNT_W-1:0] r_cnt [2];
  logic             r_last;
  logic             r_cdb_valid;
  logic             r_cdb_src;
  logic [E_W-1:0]   r_cdb;
  logic [E_W-1:0]   w_in [2];
  logic [1:0]       w_in_valid;
  logic [1:0]       w_ne;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic             w_ld;
  logic             w_gnt;
  always_comb begin
    w_in_valid = {bus.alu_valid, bus.mem_valid};
    w_in[0]    = {bus.mem_rd_we, bus.mem_prd, bus.mem_rob_idx, bus.mem_data};
    w_in[1]    = {bus.alu_rd_we, bus.alu_prd, bus.alu_rob_idx, bus.alu_data};
    for (int s = 0; s < 2; s++) begin
      w_ne[s]   = r_cnt[s] != '0;
      w_push[s] = w_in_valid[s] & (r_cnt[s] < CNT_W'(FIFO_DEPTH)) & !bus.flush;
    end
    w_ld  = !r_cdb_valid | bus.cdb_ready;
    // both pending: hand the grant to whoever did not win last time
    w_gnt = &w_ne ? !r_last : w_ne[1];
    w_pop = (w_ld & |w_ne & !bus.flush) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (w_push[s]) r_fifo[s][r_wp[s]] <= w_in[s];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        r_wp[s]  <= '0;
        r_rp[s]  <= '0;
        r_cnt[s] <= '0;
      end
      r_last      <= 1'b1;
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= 1'b0;
      r_cdb       <= '0;
    end else if (bus.flush) begin
      for (int s = 0; s < 2; s++) begin
        r_wp[s]  <= '0;
        r_rp[s]  <= '0;
        r_cnt[s] <= '0;
      end
      r_cdb_valid <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) r_wp[s] <= r_wp[s] + 1'b1;
        if (w_pop[s]) r_rp[s] <= r_rp[s] + 1'b1;
        r_cnt[s] <= r_cnt[s] + CNT_W'(w_push[s]) - CNT_W'(w_pop[s]);
      end
      if (w_ld) begin
        r_cdb_valid <= |w_ne;
        if (|w_ne) begin
          r_cdb     <= r_fifo[w_gnt][r_rp[w_gnt]];
          r_cdb_src <= w_gnt;
          r_last    <= w_gnt;
        end
      end
    end
  end
  assign bus.mem_ready = r_cnt[0] < CNT_W'(FIFO_DEPTH);
  assign bus.alu_ready = r_cnt[1] < CNT_W'(FIFO_DEPTH);
  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_src   = r_cdb_src;
  assign {bus.cdb_rd_we, bus.cdb_prd, bus.cdb_rob_idx, bus.cdb_data} = r_cdb;
endmodule

// File: doc/wb_cdb_arbiter.md
Name: wb_cdb_arbiter

Overview:
- Writeback-side consumer of the MEM/WB pipeline register and of the ALU result path.
- Buffers results from both producers in small per-source FIFOs and picks one per cycle with a round-robin arbiter.
- Drives the winner onto the single common data bus (CDB) used for physical-register-file write, ROB completion and reservation-station wakeup.
- Sits between the MEM_WB/ALU result registers and the PRF/ROB/RS consumers.

Parameters:
- DATA_W, 32, result data width
- PREG_W, 6, physical register index width
- ROB_W, 4, ROB index width
- FIFO_DEPTH, 2, entries per source FIFO; power of two, >= 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous pipeline flush (mispredict)
- mem_valid  in  1  MEM/WB result valid
- mem_ready  out  1  MEM source FIFO can accept
- mem_rd_we  in  1  result writes a destination register
- mem_prd  in  PREG_W  destination physical register
- mem_rob_idx  in  ROB_W  ROB entry
- mem_data  in  DATA_W  result data
- alu_valid, alu_ready, alu_rd_we, alu_prd, alu_rob_idx, alu_data: same as the mem_* ports, for the ALU source
- cdb_valid  out  1  broadcast valid
- cdb_ready  in  1  consumers accept broadcast
- cdb_rd_we  out  1  broadcast writes PRF
- cdb_prd  out  PREG_W  broadcast destination
- cdb_rob_idx  out  ROB_W  broadcast ROB entry
- cdb_data  out  DATA_W  broadcast data
- cdb_src  out  1  0 = MEM, 1 = ALU (debug/perf)

Behaviour:
- Reset (rst=1 at an edge):
  - Both FIFOs emptied; counts and pointers = 0.
  - cdb_valid = 0 and all cdb_* data outputs = 0.
  - Round-robin pointer last_grant = 1, so MEM has priority first.
  - rst overrides flush and all handshakes.
- Push:
  - A beat is accepted when src_valid & src_ready at the edge.
  - src_ready = (count < FIFO_DEPTH), driven from registered count only.
  - No combinational path from cdb_ready or any pop to src_ready.
- Output register:
  - The cdb_* outputs are registered.
  - Load enable = (!cdb_valid | cdb_ready).
  - When enabled: if any FIFO is non-empty, pop the granted FIFO head into the cdb regs and set cdb_valid=1; else set cdb_valid=0.
  - While cdb_valid & !cdb_ready, all cdb_* outputs hold stable.
- Arbitration:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the source != last_grant.
  - last_grant updates only on an actual pop.
- Latency: a beat accepted at edge t appears on the cdb outputs after edge t+1 at the earliest. No input-to-CDB bypass.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. Legal even at count==FIFO_DEPTH only if ready was high, which it is not; no push occurs when full.
- Pointers: wrap modulo FIFO_DEPTH. count width = clog2(FIFO_DEPTH)+1.
- Ordering: per-source order is preserved. No ordering guarantee across sources.
- cdb_rd_we=0 beats (stores, branches) are still broadcast for ROB completion.
- Flush (rst=0, flush=1 at an edge):
  - Both FIFOs cleared and cdb_valid=0.
  - Pushes presented that cycle are dropped.
  - last_grant is unchanged.
  - The cdb data registers may retain stale values while cdb_valid=0.
- A beat held on CDB with cdb_ready=0 when flush arrives is discarded, not delivered.
- Reset mid-operation: identical to the reset state above; no beat survives.

Test Plan:
- Single beat:
  - Stimulus: rst then release; mem_valid=1 one cycle with prd=5, rob=3, data=0xDEADBEEF, rd_we=1; cdb_ready=1.
  - Required: cdb_valid=1 exactly one cycle after the acceptance edge; fields match; cdb_src=0.
- Simultaneous sources:
  - Stimulus: mem and alu each present 3 beats back-to-back, data 0x10..0x12 and 0x20..0x22; cdb_ready=1.
  - Required: CDB order 0x10, 0x20, 0x11, 0x21, 0x12, 0x22; per-source order preserved.
- Backpressure:
  - Stimulus: cdb_ready=0; push 3 MEM beats.
  - Required: first beat loads to CDB and holds stable; FIFO fills to 2; mem_ready=0 on the next cycle.
  - Then: raise cdb_ready; remaining beats drain in order; mem_ready returns to 1.
- Flush:
  - Stimulus: CDB holding a stalled beat and 2 beats queued per source; assert flush with mem_valid=1.
  - Required: next cycle cdb_valid=0, both readys=1, no flushed or same-cycle beat ever appears on CDB.
- Reset mid-traffic:
  - Stimulus: assert rst during continuous alu pushes.
  - Required: cdb outputs all 0, readys=1 after the edge; first post-reset simultaneous beats grant MEM first.
- Non-writing beat:
  - Stimulus: alu beat with rd_we=0, rob=7.
  - Required: broadcast with cdb_valid=1, cdb_rd_we=0, cdb_rob_idx=7.
